// File: rtl/uart_tx_framer_if.sv
// Word handshake between the producer and the UART transmit framer.
interface uart_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;

    // Producer side drives the word and its valid flag
    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    // Framer side accepts the word and reports buffer space
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, LSB-first data, optional parity, stop bits,
// paced by rising edges of the baud generator square wave. A one-word holding
// register allows frames to follow each other with no idle gap.
module uart_tx_framer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 1,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,     // active-high asynchronous reset
    input  logic                    baud_clk,
    uart_tx_framer_if.slave         in_if,
    output logic                    tx,
    output logic                    tx_busy,
    output logic                    tx_done
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 baud_q;
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic                 in_ready_q, in_ready_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 tick_c;
    logic                 accept_c;

    // baud_clk shares clk, so a single register is enough for edge detection
    assign tick_c   = baud_clk & ~baud_q;
    assign accept_c = in_if.in_valid & in_ready_q;

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        if (accept_c) begin
            hold_d      = in_if.in_data;
            hold_full_d = 1'b1;
        end

        if (tick_c) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        parity_d    = (^hold_q) ^ 1'(PARITY_ODD);
                        hold_full_d = 1'b0;
                        state_d     = S_START;
                        tx_d        = 1'b0;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                S_START: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = S_STOP;
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
                S_PARITY: begin
                    state_d    = S_STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            // back-to-back: next start bit follows the stop bit directly
                            shift_d     = hold_q;
                            parity_d    = (^hold_q) ^ 1'(PARITY_ODD);
                            hold_full_d = 1'b0;
                            state_d     = S_START;
                            tx_d        = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        in_ready_d = ~hold_full_d;
        busy_d     = (state_d != S_IDLE);
    end

    // State and datapath registers; reset forces the line idle immediately
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            baud_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            in_ready_q  <= 1'b1;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_clk;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            in_ready_q  <= in_ready_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign tx             = tx_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: three configurations share clk/reset/baud_clk.
// dut 0: 8 data, even parity, 1 stop; dut 1: 8 data, odd parity, 1 stop;
// dut 2: 7 data, no parity, 2 stops. Divisor 4 gives 8-cycle bits.
module tb_uart_tx_framer;

    logic clk      = 1'b0;
    logic rst_n    = 1'b1;
    logic baud_clk = 1'b0;
    int   bdiv     = 0;

    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    uart_tx_framer_if #(.DATA_BITS(8)) if_a ();
    uart_tx_framer_if #(.DATA_BITS(8)) if_b ();
    uart_tx_framer_if #(.DATA_BITS(7)) if_c ();

    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .in_if(if_a),
        .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));
    uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .in_if(if_b),
        .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));
    uart_tx_framer #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .in_if(if_c),
        .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

    always #5 clk = ~clk;

    // Baud generator model, divisor 4
    always @(negedge clk) begin
        if (bdiv == 3) begin
            bdiv     = 0;
            baud_clk = ~baud_clk;
        end else begin
            bdiv++;
        end
    end

    typedef struct {
        int          dut;
        logic [11:0] bits;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [11:0] mbits  [3];
    int          midx   [3];
    bit          minf   [3];
    logic        mlast  [3];
    int          mend   [3];
    int          mgap   [3];
    int          frames [3];
    int          ticks = 0;
    logic        baud_prev = 1'b0;

    function automatic logic get_tx(input int d);
        case (d)
            0: return tx_a;
            1: return tx_b;
            default: return tx_c;
        endcase
    endfunction

    function automatic logic get_busy(input int d);
        case (d)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic get_done(input int d);
        case (d)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic get_ready(input int d);
        case (d)
            0: return if_a.in_ready;
            1: return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    function automatic int frame_len(input int d);
        return (d == 2) ? 10 : 11;
    endfunction

    // Reference frame builder, bit i is the i-th bit on the line
    function automatic logic [11:0] mk_frame(input int d, input logic [8:0] data);
        logic [11:0] f;
        int          db, ns, pos;
        bit          pen;
        logic        p;
        db  = (d == 2) ? 7 : 8;
        ns  = (d == 2) ? 2 : 1;
        pen = (d != 2);
        p   = (d == 1);
        f   = '0;
        for (int i = 0; i < db; i++) begin
            f[1 + i] = data[i];
            p        = p ^ data[i];
        end
        pos = 1 + db;
        if (pen) begin
            f[pos] = p;
            pos++;
        end
        for (int s = 0; s < ns; s++) f[pos + s] = 1'b1;
        return f;
    endfunction

    // Line monitor and scoreboard: samples every dut just after each clk edge
    always @(posedge clk) begin
        logic tk;
        logic t, b, dn;
        exp_t e;
        tk        = baud_clk & ~baud_prev;
        baud_prev = rst_n ? 1'b0 : baud_clk;
        #1;
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                minf[d]  = 1'b0;
                midx[d]  = 0;
                mlast[d] = 1'b1;
            end
        end else begin
            if (tk) ticks++;
            for (int d = 0; d < 3; d++) begin
                t  = get_tx(d);
                b  = get_busy(d);
                dn = get_done(d);
                if (tk) begin
                    n_checks++;
                    if (minf[d] && midx[d] == frame_len(d)) begin
                        if (dn !== 1'b1) begin
                            n_fail++;
                            $display("FAIL done_at_frame_end dut%0d: tx_done=%b required 1 at %0t", d, dn, $time);
                        end
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL unexpected_frame dut%0d: got %h with no expectation at %0t", d, mbits[d], $time);
                        end else begin
                            e = exp_q.pop_front();
                            if (e.dut != d || e.bits !== mbits[d]) begin
                                n_fail++;
                                $display("FAIL frame_bits dut%0d: got %h required %h (dut %0d) at %0t",
                                         d, mbits[d], e.bits, e.dut, $time);
                            end
                        end
                        frames[d]++;
                        mend[d] = ticks;
                        minf[d] = 1'b0;
                    end else if (dn !== 1'b0) begin
                        n_fail++;
                        $display("FAIL spurious_done dut%0d: tx_done=%b required 0 at %0t", d, dn, $time);
                    end
                    n_checks++;
                    if (minf[d]) begin
                        mbits[d][midx[d]] = t;
                        midx[d]++;
                        if (b !== 1'b1) begin
                            n_fail++;
                            $display("FAIL busy_in_frame dut%0d: tx_busy=%b required 1 at %0t", d, b, $time);
                        end
                    end else if (t === 1'b0) begin
                        minf[d]  = 1'b1;
                        mbits[d] = '0;
                        midx[d]  = 1;
                        mgap[d]  = ticks - mend[d];
                        if (b !== 1'b1) begin
                            n_fail++;
                            $display("FAIL busy_at_start dut%0d: tx_busy=%b required 1 at %0t", d, b, $time);
                        end
                    end else if (t !== 1'b1 || b !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle_line dut%0d: tx=%b tx_busy=%b required tx=1 tx_busy=0 at %0t", d, t, b, $time);
                    end
                    mlast[d] = t;
                end else begin
                    n_checks++;
                    if (t !== mlast[d] || dn !== 1'b0) begin
                        n_fail++;
                        $display("FAIL between_ticks dut%0d: tx=%b tx_done=%b required tx=%b tx_done=0 at %0t",
                                 d, t, dn, mlast[d], $time);
                    end
                end
            end
        end
    end

    task automatic drive(input int d, input logic valid, input logic [8:0] data);
        case (d)
            0: begin if_a.in_valid = valid; if_a.in_data = data[7:0]; end
            1: begin if_b.in_valid = valid; if_b.in_data = data[7:0]; end
            default: begin if_c.in_valid = valid; if_c.in_data = data[6:0]; end
        endcase
    endtask

    // Offer a word, wait for the handshake, record the expected frame
    task automatic send(input int d, input logic [8:0] data, input logic [11:0] frame,
                        input bit expect_it, input bit keep);
        int guard;
        @(negedge clk);
        drive(d, 1'b1, data);
        guard = 0;
        while (get_ready(d) !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (get_ready(d) !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL handshake_timeout dut%0d: in_ready=%b required 1 at %0t", d, get_ready(d), $time);
            drive(d, 1'b0, 9'h0);
            return;
        end
        @(posedge clk);
        if (expect_it) exp_q.push_back('{dut: d, bits: frame});
        @(negedge clk);
        n_checks++;
        if (get_ready(d) !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_accept dut%0d: in_ready=%b required 0 at %0t", d, get_ready(d), $time);
        end
        if (!keep) drive(d, 1'b0, 9'h0);
    endtask

    task automatic wait_frames(input int d, input int target);
        int guard;
        guard = 0;
        while (frames[d] < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (frames[d] < target) begin
            n_fail++;
            $display("FAIL frame_timeout dut%0d: frames=%0d required %0d at %0t", d, frames[d], target, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (get_tx(d) !== 1'b1 || get_ready(d) !== 1'b1 ||
                get_busy(d) !== 1'b0 || get_done(d) !== 1'b0) begin
                n_fail++;
                $display("FAIL %s dut%0d: tx=%b in_ready=%b tx_busy=%b tx_done=%b required 1 1 0 0",
                         tag, d, get_tx(d), get_ready(d), get_busy(d), get_done(d));
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_release");
        repeat (20) @(negedge clk);
        check_idle_outputs("idle_no_word");
    endtask

    task automatic test_even_parity();
        int target, busy_cycles, done_pulses, guard;
        target = frames[0] + 1;
        send(0, 9'h0A5, 12'h54A, 1'b1, 1'b0);
        busy_cycles = 0;
        done_pulses = 0;
        guard       = 0;
        while (!(frames[0] >= target && busy_a === 1'b0) && guard < 300) begin
            @(negedge clk);
            if (busy_a === 1'b1) busy_cycles++;
            if (done_a === 1'b1) done_pulses++;
            guard++;
        end
        n_checks++;
        if (busy_cycles != 88) begin
            n_fail++;
            $display("FAIL busy_length: tx_busy high %0d cycles required 88", busy_cycles);
        end
        n_checks++;
        if (done_pulses != 1) begin
            n_fail++;
            $display("FAIL done_count: tx_done pulsed %0d cycles required 1", done_pulses);
        end
    endtask

    task automatic test_odd_parity();
        int t1, t0;
        t1 = frames[1] + 1;
        t0 = frames[0] + 1;
        send(1, 9'h001, 12'h402, 1'b1, 1'b0);
        wait_frames(1, t1);
        send(0, 9'h001, 12'h602, 1'b1, 1'b0);
        wait_frames(0, t0);
    endtask

    task automatic test_back_to_back();
        int target;
        target = frames[0] + 2;
        send(0, 9'h055, mk_frame(0, 9'h055), 1'b1, 1'b1);
        send(0, 9'h00F, mk_frame(0, 9'h00F), 1'b1, 1'b0);
        wait_frames(0, target);
        n_checks++;
        if (mgap[0] != 0) begin
            n_fail++;
            $display("FAIL back_to_back_gap: %0d idle bits between frames required 0", mgap[0]);
        end
    endtask

    task automatic test_no_parity_two_stop();
        int target, done_pulses, guard;
        target = frames[2] + 1;
        send(2, 9'h07F, 12'h3FE, 1'b1, 1'b0);
        done_pulses = 0;
        guard       = 0;
        while (frames[2] < target && guard < 300) begin
            @(negedge clk);
            if (done_c === 1'b1) done_pulses++;
            guard++;
        end
        n_checks++;
        if (done_pulses != 1 || frames[2] < target) begin
            n_fail++;
            $display("FAIL two_stop_done: tx_done pulses %0d frames %0d required 1 and %0d",
                     done_pulses, frames[2], target);
        end
    endtask

    task automatic test_reset_midframe();
        int guard, target;
        send(0, 9'h0C3, 12'h000, 1'b0, 1'b0);
        guard = 0;
        while (!(minf[0] && midx[0] == 5) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (!(minf[0] && midx[0] == 5)) begin
            n_fail++;
            $display("FAIL reach_data_bit3: in_frame=%b bit_index=%0d required 1 and 5", minf[0], midx[0]);
        end
        @(negedge clk);
        n_checks++;
        if (tx_a !== 1'b0) begin
            n_fail++;
            $display("FAIL data_bit3_value: tx=%b required 0", tx_a);
        end
        #2;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (tx_a !== 1'b1 || if_a.in_ready !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: tx=%b in_ready=%b tx_busy=%b required 1 1 0",
                     tx_a, if_a.in_ready, busy_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (30) @(negedge clk);
        target = frames[0] + 1;
        send(0, 9'h03C, mk_frame(0, 9'h03C), 1'b1, 1'b0);
        wait_frames(0, target);
    endtask

    task automatic test_stalled();
        int bad, lat, target;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stalled_idle: %0d cycles not idle required 0", bad);
        end
        repeat (3) @(negedge clk);
        target = frames[0] + 1;
        send(0, 9'h096, mk_frame(0, 9'h096), 1'b1, 1'b0);
        lat = 0;
        while (tx_a === 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat < 1 || lat > 8) begin
            n_fail++;
            $display("FAIL start_latency: %0d cycles required 1..8", lat);
        end
        wait_frames(0, target);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            minf[d]   = 1'b0;
            midx[d]   = 0;
            mlast[d]  = 1'b1;
            mend[d]   = 0;
            mgap[d]   = -1;
            frames[d] = 0;
            mbits[d]  = '0;
            drive(d, 1'b0, 9'h0);
        end
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_back_to_back();
        test_no_parity_two_stop();
        test_reset_midframe();
        test_stalled();
        repeat (20) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_expected: %0d frames never seen required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_framer.md
# uart_tx_framer

Serial transmit framer that sits directly downstream of the UART baud generator. It consumes the generator's `baud_clk` square wave and converts parallel words, accepted over a valid/ready handshake, into UART frames on `tx`. A frame is start bit, data bits LSB first, optional parity bit, then stop bits. A one-word holding register lets the next word be accepted while the current frame shifts out, so frames can be sent back-to-back with no idle gap.

## Interface

Parameters:
- `DATA_BITS`, default 8: data bits per frame. Legal range 5–9.
- `PARITY_EN`, default 1: 1 inserts a parity bit after the data bits; 0 omits it.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits. Legal values 1 or 2.

Ports:
- `clk`, input, 1: system clock. Same clock that drives the baud generator.
- `rst_n`, input, 1: reset. **Asynchronous, active-high**; the port keeps the codebase name.
- `baud_clk`, input, 1: square wave from the baud generator, synchronous to `clk`. One bit period equals 2×divisor `clk` cycles.
- `in_data`, input, `DATA_BITS`: word to transmit.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: holding register is empty and can accept a word.
- `tx`, output, 1: serial line. Idles high.
- `tx_busy`, output, 1: a frame is in progress, i.e. FSM is not in IDLE.
- `tx_done`, output, 1: one-cycle pulse at the end of the final stop bit.

## Operation

- **Bit tick.** `baud_q` registers `baud_clk` every cycle. `tick = baud_clk & ~baud_q` is a one-cycle pulse on each rising edge of `baud_clk`. No synchroniser is used, because `baud_clk` is on the same clock.
- **Handshake.** A transfer occurs on a `clk` edge where `in_valid & in_ready`. `in_data` loads the holding register and sets `hold_full`. `in_ready = ~hold_full`, driven from a register.
- **FSM states.** IDLE, START, DATA, PARITY, STOP. All transitions happen only on cycles where `tick`=1.
  - IDLE with `hold_full`: copy holding into the shift register, clear `hold_full`, go to START, `tx`←0. With `hold_full`=0, stay in IDLE with `tx`=1.
  - START → DATA: `tx`←shift[0]; bit counter←0.
  - DATA: shift right and increment the counter. After `DATA_BITS` bits, go to PARITY if `PARITY_EN`, otherwise to STOP. `tx` takes the next bit, or the parity bit, or 1.
  - PARITY → STOP: `tx`←1.
  - STOP: after `STOP_BITS` ticks the frame ends and `tx_done` pulses in that same cycle.
    - If `hold_full`=1: load the shift register, clear `hold_full`, go to START, `tx`←0. This is the back-to-back case.
    - Otherwise go to IDLE.
- **Parity.** Parity = XOR of the data bits, XOR `PARITY_ODD`. It is computed when the shift register is loaded.
- **Simultaneous events.** A handshake in the same cycle the holding register is emptied cannot occur, because `in_ready` is registered low while holding is full. The word is accepted on the next cycle.
- **Counters.** Bit counter width is clog2(`DATA_BITS`+1). Stop counter width is 1 bit.
- **Reset (asynchronous, any time, including mid-frame):**
  - FSM←IDLE; holding and shift registers cleared; `baud_q`←0.
  - Output values during reset: `tx`=1, `in_ready`=1, `tx_busy`=0, `tx_done`=0.
  - A partial frame is abandoned with `tx` high immediately, not at the next edge.

## Timing

- Each bit is held for exactly one tick interval, 2×divisor `clk` cycles.
- Frame length = 1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS` bit periods.
- `tx` and `tx_busy` change on the `clk` edge at which `tick`=1, i.e. one cycle after `baud_clk` rises.
- Latency from accepted word to start bit: 1 to 2×divisor cycles, set by the next tick.
- `in_ready` is low from the edge after acceptance until the edge at which the word moves to the shift register.
- Back-to-back frames: the last stop bit is followed immediately by the next start bit, with no idle bit.
- Reset release: the first tick after release may start a frame only if a word was accepted after release.

## Test plan

1. **Even parity frame.** Divisor 4 (8-cycle bits), defaults, send 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,0,1. Each bit lasts 8 cycles. `tx_done` pulses once; `tx_busy` is high for 88 cycles.
2. **Odd parity.** `PARITY_ODD`=1, send 0x01 → parity bit 0. With `PARITY_ODD`=0, send 0x01 → parity bit 1.
3. **Back-to-back.** Hold `in_valid` with 0x55 then 0x0F → second start bit begins on the tick right after the first stop bit. `in_ready` deasserts after each accept. No idle bits between frames.
4. **No parity, 2 stop bits.** `PARITY_EN`=0, `STOP_BITS`=2, `DATA_BITS`=7, send 0x7F → 10-bit frame 0,1×7,1,1. `tx_done` pulses at the end of the second stop bit.
5. **Reset mid-frame.** Assert `rst_n` during data bit 3 → `tx`=1 asynchronously, `in_ready`=1, `tx_busy`=0. After release, a new 0x3C transmits a clean frame.
6. **Stalled input.** `in_valid`=0 for 50 bit periods → `tx` stays 1, `tx_busy`=0, no `tx_done` pulses. Then a word arrives → start bit at the next tick.
